// File: rtl/cache_bus_pkg.sv
// Shared definitions for the CPU-side cache bus (C1 command, A1 address, D1 data).
// Holds the C1 command codes, address field widths, bus widths, the bus-master
// state encoding and small helpers for command decode and read-data formatting.
package cache_bus_pkg;

  // Byte address split: tag | set | offset
  localparam int unsigned TAG_W  = 10;
  localparam int unsigned SET_W  = 5;
  localparam int unsigned OFFS_W = 4;
  localparam int unsigned A1_W   = TAG_W + SET_W;

  localparam int unsigned C1_W   = 3;
  localparam int unsigned D1_W   = 16;
  localparam int unsigned DATA_W = 32;

  // C1 command codes driven by the master
  localparam logic [C1_W-1:0] C1_NOP             = 3'd0;
  localparam logic [C1_W-1:0] C1_READ8           = 3'd1;
  localparam logic [C1_W-1:0] C1_READ16          = 3'd2;
  localparam logic [C1_W-1:0] C1_READ32          = 3'd3;
  localparam logic [C1_W-1:0] C1_INVALIDATE_LINE = 3'd4;
  localparam logic [C1_W-1:0] C1_WRITE8          = 3'd5;
  localparam logic [C1_W-1:0] C1_WRITE16         = 3'd6;
  localparam logic [C1_W-1:0] C1_WRITE32         = 3'd7;

  // Same code as WRITE32; meaning depends on who is driving C1
  localparam logic [C1_W-1:0] C1_RESPONSE        = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    OFF,
    TURN,
    WAIT,
    RESP2,
    DONE
  } state_t;

  function automatic logic is_write(input logic [C1_W-1:0] cmd);
    return (cmd == C1_WRITE8) || (cmd == C1_WRITE16) || (cmd == C1_WRITE32);
  endfunction

  // Assemble the returned word from the captured response beats
  function automatic logic [DATA_W-1:0] format_rsp(input logic [C1_W-1:0] cmd,
                                                   input logic [D1_W-1:0] b0,
                                                   input logic [D1_W-1:0] b1);
    case (cmd)
      C1_READ8:  return DATA_W'(b0[7:0]);
      C1_READ16: return DATA_W'(b0);
      C1_READ32: return {b1, b0};
      default:   return '0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter.
// Ports: clk, rst_n (sync, active-low); req[1:0] requests; advance = arbitration
// window open (pointer may move); grant_c[1:0] combinational one-hot grant.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant_c
);

  // ptr names the port that wins when both request
  logic ptr;

  always_comb begin
    grant_c = req;
    if (req == 2'b11) begin
      grant_c = ptr ? 2'b10 : 2'b01;
    end
  end

  // After any grant the other port gets priority
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (advance && (req != 2'b00)) begin
      ptr <= ~grant_c[1];
    end
  end

endmodule

// File: rtl/c1_bus_master.sv
// Two-requester master for the C1/A1/D1 cache bus.
// Ports: clk, rst_n (sync, active-low); req_valid/req_ready/req_cmd/req_addr/req_wdata
// per-port request handshake; rsp_valid/rsp_rdata/rsp_err completion; busy = not idle;
// C1 (inout command), A1 (address, tri-stated), D1 (inout data).
// A granted request is sent as two beats (line address, then offset), the bus is
// handed to the cache for one turnaround cycle, and the cache's response beats are
// collected into a 32-bit result returned to the owning port.
module c1_bus_master
  import cache_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned ADDR_W  = OFFS_W + A1_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0][C1_W-1:0]   req_cmd,
  input  logic [1:0][ADDR_W-1:0] req_addr,
  input  logic [1:0][DATA_W-1:0] req_wdata,
  output logic [1:0]             rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic                   busy,
  inout  wire  [C1_W-1:0]        C1,
  output wire  [A1_W-1:0]        A1,
  inout  wire  [D1_W-1:0]        D1
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_t            state;
  logic              owner;
  logic [C1_W-1:0]   cmd_q;
  logic [OFFS_W-1:0] off_q;
  logic [D1_W-1:0]   d1_off_q;
  logic [D1_W-1:0]   beat0_q;
  logic [CNT_W-1:0]  cnt;

  logic              bus_oe;
  logic              d1_oe;
  logic [C1_W-1:0]   c1_q;
  logic [A1_W-1:0]   a1_q;
  logic [D1_W-1:0]   d1_q;

  logic [1:0]        grant_c;
  logic              sel_c;
  logic [C1_W-1:0]   sel_cmd_c;
  logic [ADDR_W-1:0] sel_addr_c;
  logic [DATA_W-1:0] sel_wdata_c;
  logic [1:0]        owner_oh_c;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (state == IDLE),
    .grant_c (grant_c)
  );

  // Grant is one-hot, so bit 1 is the selected port index
  assign sel_c       = grant_c[1];
  assign sel_cmd_c   = req_cmd[sel_c];
  assign sel_addr_c  = req_addr[sel_c];
  assign sel_wdata_c = req_wdata[sel_c];
  assign owner_oh_c  = owner ? 2'b10 : 2'b01;

  // Buses are released whenever the output enables are low
  assign C1 = bus_oe ? c1_q : 'z;
  assign A1 = bus_oe ? a1_q : 'z;
  assign D1 = d1_oe  ? d1_q : 'z;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= 1'b0;
      cmd_q     <= C1_NOP;
      off_q     <= '0;
      d1_off_q  <= '0;
      beat0_q   <= '0;
      cnt       <= '0;
      bus_oe    <= 1'b0;
      d1_oe     <= 1'b0;
      c1_q      <= '0;
      a1_q      <= '0;
      d1_q      <= '0;
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      unique case (state)
        IDLE: begin
          if (grant_c != 2'b00) begin
            owner     <= sel_c;
            cmd_q     <= sel_cmd_c;
            off_q     <= sel_addr_c[OFFS_W-1:0];
            // Second data beat: upper half only for full-word writes
            d1_off_q  <= (sel_cmd_c == C1_WRITE32) ? sel_wdata_c[31:16] : sel_wdata_c[15:0];
            req_ready <= grant_c;
            busy      <= 1'b1;
            if (sel_cmd_c == C1_NOP) begin
              // Illegal command: complete immediately with an error, bus untouched
              state     <= DONE;
              rsp_valid <= grant_c;
              rsp_rdata <= '0;
              rsp_err   <= 1'b1;
            end else begin
              state  <= ADDR;
              bus_oe <= 1'b1;
              d1_oe  <= is_write(sel_cmd_c);
              c1_q   <= sel_cmd_c;
              a1_q   <= A1_W'(sel_addr_c >> OFFS_W);
              d1_q   <= sel_wdata_c[15:0];
            end
          end
        end
        ADDR: begin
          state <= OFF;
          a1_q  <= A1_W'(off_q);
          d1_q  <= d1_off_q;
        end
        OFF: begin
          state  <= TURN;
          bus_oe <= 1'b0;
          d1_oe  <= 1'b0;
        end
        TURN: begin
          state <= WAIT;
          cnt   <= '0;
        end
        WAIT: begin
          // C1 is only sampled here, while this block has released it
          if (C1 == C1_RESPONSE) begin
            beat0_q <= D1;
            if (cmd_q == C1_READ32) begin
              state <= RESP2;
            end else begin
              state     <= DONE;
              rsp_valid <= owner_oh_c;
              rsp_rdata <= format_rsp(cmd_q, D1, '0);
              rsp_err   <= 1'b0;
            end
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            state     <= DONE;
            rsp_valid <= owner_oh_c;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP2: begin
          // Cache drives the second beat right after the first
          state     <= DONE;
          rsp_valid <= owner_oh_c;
          rsp_rdata <= format_rsp(cmd_q, beat0_q, D1);
          rsp_err   <= 1'b0;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          bus_oe <= 1'b0;
          d1_oe  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_c1_bus_master.sv
// Directed bench for c1_bus_master with a simple cache-side bus model.
module tb_c1_bus_master;

  localparam int TIMEOUT = 64;

  logic             clk;
  logic             rst_n;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][2:0]  req_cmd;
  logic [1:0][18:0] req_addr;
  logic [1:0][31:0] req_wdata;
  logic [1:0]       rsp_valid;
  logic [31:0]      rsp_rdata;
  logic             rsp_err;
  logic             busy;
  wire  [2:0]       C1;
  wire  [14:0]      A1;
  wire  [15:0]      D1;

  // Cache-side drivers
  logic        cache_en;
  logic [2:0]  cache_c1;
  logic [15:0] cache_d1;
  assign C1 = cache_en ? cache_c1 : 'z;
  assign D1 = cache_en ? cache_d1 : 'z;

  // Follow-on request loaded into a port the moment it is granted
  logic [1:0]       nxt_valid;
  logic [1:0][2:0]  nxt_cmd;
  logic [1:0][18:0] nxt_addr;
  logic [1:0][31:0] nxt_wdata;

  int n_checks = 0;
  int n_pass   = 0;

  c1_bus_master #(.TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_cmd   (req_cmd),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .C1        (C1),
    .A1        (A1),
    .D1        (D1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // A released bus reads as z (4-state) or 0 (2-state with no driver)
  function automatic bit released(input logic [15:0] v);
    return $isunknown(v) || (v == 16'h0000);
  endfunction

  task automatic check_released(input string tag);
    check({tag, "_c1_z"}, 32'(released(16'(C1))), 32'd1);
    check({tag, "_a1_z"}, 32'(released(16'(A1))), 32'd1);
    check({tag, "_d1_z"}, 32'(released(D1)), 32'd1);
  endtask

  task automatic set_req(input int port, input logic [2:0] cmd, input logic [18:0] addr,
                         input logic [31:0] wdata);
    req_valid[port] = 1'b1;
    req_cmd[port]   = cmd;
    req_addr[port]  = addr;
    req_wdata[port] = wdata;
  endtask

  // Follows one transaction from grant to the idle cycle after completion.
  // respond=0 leaves the cache silent so the master must time out.
  task automatic run_txn(input int port, input logic [2:0] cmd, input logic [18:0] addr,
                         input logic [31:0] wdata, input bit respond, input int delay,
                         input logic [15:0] b0, input logic [15:0] b1,
                         input logic [31:0] exp_rdata, input bit exp_err);
    int n;
    logic [1:0] exp_oh;
    bit wr;
    exp_oh = (port == 1) ? 2'b10 : 2'b01;
    wr = (cmd == 3'd5) || (cmd == 3'd6) || (cmd == 3'd7);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ready == 2'b00 && n < 100);
    check("grant", 32'(req_ready), 32'(exp_oh));
    req_valid[port] = nxt_valid[port];
    req_cmd[port]   = nxt_cmd[port];
    req_addr[port]  = nxt_addr[port];
    req_wdata[port] = nxt_wdata[port];
    nxt_valid[port] = 1'b0;
    if (cmd == 3'd0) begin
      check("nop_rsp_valid", 32'(rsp_valid), 32'(exp_oh));
      check("nop_rsp_err", 32'(rsp_err), 32'd1);
      check("nop_rdata", rsp_rdata, 32'h0);
      check_released("nop");
    end else begin
      check("addr_c1", 32'(C1), 32'(cmd));
      check("addr_a1", 32'(A1), 32'(addr[18:4]));
      if (wr) check("addr_d1", 32'(D1), 32'(wdata[15:0]));
      else    check("addr_d1_z", 32'(released(D1)), 32'd1);
      @(negedge clk);
      check("off_c1", 32'(C1), 32'(cmd));
      check("off_a1", 32'(A1), 32'(addr[3:0]));
      if (wr) check("off_d1", 32'(D1), (cmd == 3'd7) ? 32'(wdata[31:16]) : 32'(wdata[15:0]));
      else    check("off_d1_z", 32'(released(D1)), 32'd1);
      @(negedge clk);
      check_released("turn");
      if (respond) begin
        repeat (delay) @(negedge clk);
        cache_en = 1'b1;
        cache_c1 = 3'd7;
        cache_d1 = b0;
        if (cmd == 3'd3) begin
          @(negedge clk);
          check("r32_gap_valid", 32'(rsp_valid), 32'd0);
          cache_d1 = b1;
        end
        @(negedge clk);
        cache_en = 1'b0;
        #1;
      end else begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (rsp_valid == 2'b00 && n < 200);
        check("timeout_cycles", 32'(n), 32'(TIMEOUT + 1));
      end
      check("rsp_valid", 32'(rsp_valid), 32'(exp_oh));
      check("rsp_rdata", rsp_rdata, exp_rdata);
      check("rsp_err", 32'(rsp_err), 32'(exp_err));
      check("done_busy", 32'(busy), 32'd1);
      check_released("done");
    end
    @(negedge clk);
    check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    check("idle_ready", 32'(req_ready), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n     = 1'b0;
    req_valid = '0;
    req_cmd   = '0;
    req_addr  = '0;
    req_wdata = '0;
    cache_en  = 1'b0;
    cache_c1  = '0;
    cache_d1  = '0;
    nxt_valid = '0;
    nxt_cmd   = '0;
    nxt_addr  = '0;
    nxt_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rdata", rsp_rdata, 32'h0);
    check_released("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // T1: port0 READ8
    set_req(0, 3'd1, 19'h00123, 32'h0);
    run_txn(0, 3'd1, 19'h00123, 32'h0, 1'b1, 2, 16'hABCD, 16'h0, 32'h000000CD, 1'b0);

    // T2: port1 WRITE32
    set_req(1, 3'd7, 19'h7FFF0, 32'hDEADBEEF);
    run_txn(1, 3'd7, 19'h7FFF0, 32'hDEADBEEF, 1'b1, 1, 16'h0000, 16'h0, 32'h0, 1'b0);

    // T3: port0 READ32, two back-to-back beats
    set_req(0, 3'd3, 19'h12345, 32'h0);
    run_txn(0, 3'd3, 19'h12345, 32'h0, 1'b1, 3, 16'h1111, 16'h2222, 32'h22221111, 1'b0);

    // T5: port1 READ16 with a silent cache
    set_req(1, 3'd2, 19'h04440, 32'h0);
    run_txn(1, 3'd2, 19'h04440, 32'h0, 1'b0, 0, 16'h0, 16'h0, 32'h0, 1'b1);

    // T4: both ports keep requesting; grants must alternate 0,1,0,1
    set_req(0, 3'd2, 19'h0AAA0, 32'h0);
    set_req(1, 3'd5, 19'h55551, 32'h000000A5);
    nxt_valid = 2'b11;
    nxt_cmd[0] = 3'd4; nxt_addr[0] = 19'h01230; nxt_wdata[0] = 32'h0;
    nxt_cmd[1] = 3'd1; nxt_addr[1] = 19'h7FFFF; nxt_wdata[1] = 32'h0;
    run_txn(0, 3'd2, 19'h0AAA0, 32'h0, 1'b1, 1, 16'h8001, 16'h0, 32'h00008001, 1'b0);
    run_txn(1, 3'd5, 19'h55551, 32'h000000A5, 1'b1, 2, 16'h0000, 16'h0, 32'h0, 1'b0);
    run_txn(0, 3'd4, 19'h01230, 32'h0, 1'b1, 1, 16'h0000, 16'h0, 32'h0, 1'b0);
    run_txn(1, 3'd1, 19'h7FFFF, 32'h0, 1'b1, 4, 16'hFF80, 16'h0, 32'h00000080, 1'b0);

    // Illegal command completes at once with an error
    set_req(1, 3'd0, 19'h00010, 32'h0);
    run_txn(1, 3'd0, 19'h00010, 32'h0, 1'b0, 0, 16'h0, 16'h0, 32'h0, 1'b1);

    // T6: reset while waiting, with a response on the bus in the reset cycle
    set_req(0, 3'd1, 19'h00200, 32'h0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ready == 2'b00 && n < 100);
    check("t6_grant", 32'(req_ready), 32'd1);
    req_valid[0] = 1'b0;
    repeat (5) @(negedge clk);
    check("t6_busy_wait", 32'(busy), 32'd1);
    rst_n    = 1'b0;
    cache_en = 1'b1;
    cache_c1 = 3'd7;
    cache_d1 = 16'h1234;
    @(negedge clk);
    cache_en = 1'b0;
    #1;
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_released("t6_rst");
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_after_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t6_after_rdata", rsp_rdata, 32'h0);
    set_req(0, 3'd2, 19'h00300, 32'h0);
    set_req(1, 3'd2, 19'h00400, 32'h0);
    run_txn(0, 3'd2, 19'h00300, 32'h0, 1'b1, 1, 16'h0101, 16'h0, 32'h00000101, 1'b0);
    run_txn(1, 3'd2, 19'h00400, 32'h0, 1'b1, 1, 16'h0202, 16'h0, 32'h00000202, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
